// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for a single-master request/response port.
// Accepts one request at a time (read, or write when RECEIVE_DATA_VALID accompanies the
// address), waits LATENCY cycles, then returns one response word: read data, or the
// echoed write data as a write acknowledge. Backing store is an internal word RAM whose
// contents survive reset.
//
// Ports:
//   CLK                 in   clock, all logic on posedge
//   RST                 in   synchronous reset, active-high
//   RECEIVE_ADDR_VALID  in   request valid
//   RECEIVE_ADDR        in   word address (only the low DEPTH_LOG2 bits are used)
//   RECEIVE_DATA_VALID  in   request is a write when high together with ADDR_VALID
//   RECEIVE_DATA        in   write data
//   RECEIVE_READY       out  responder can accept a request
//   SEND_VALID          out  response valid
//   SEND_DATA           out  read data or echoed write data
//   SEND_READY          in   requester accepts the response
//
// LATENCY must be at least 1.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RECEIVE_ADDR_VALID,
    input  logic [ADDR_WIDTH-1:0] RECEIVE_ADDR,
    input  logic                  RECEIVE_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] RECEIVE_DATA,
    output logic                  RECEIVE_READY,
    output logic                  SEND_VALID,
    output logic [DATA_WIDTH-1:0] SEND_DATA,
    input  logic                  SEND_READY
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    is_wr_q, is_wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    send_valid_q, send_valid_d;
    logic [DATA_WIDTH-1:0]   send_data_q, send_data_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    // Upper address bits alias onto the same RAM words by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^RECEIVE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2];

    assign RECEIVE_READY = (state_q == StIdle) && !RST;
    assign SEND_VALID    = send_valid_q;
    assign SEND_DATA     = send_data_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        is_wr_d      = is_wr_q;
        wdata_d      = wdata_q;
        send_valid_d = send_valid_q;
        send_data_d  = send_data_q;
        mem_we       = 1'b0;

        case (state_q)
            StIdle: begin
                // Request fields are captured only here; later input changes are ignored.
                if (RECEIVE_ADDR_VALID) begin
                    idx_d   = RECEIVE_ADDR[DEPTH_LOG2-1:0];
                    is_wr_d = RECEIVE_DATA_VALID;
                    wdata_d = RECEIVE_DATA;
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    // Commit edge: a read sees the stored value, a write echoes its data.
                    mem_we       = is_wr_q;
                    send_data_d  = is_wr_q ? wdata_q : mem_q[idx_q];
                    send_valid_d = 1'b1;
                    state_d      = StRespond;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRespond: begin
                if (SEND_READY) begin
                    send_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            is_wr_q      <= 1'b0;
            wdata_q      <= '0;
            send_valid_q <= 1'b0;
            send_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            is_wr_q      <= is_wr_d;
            wdata_q      <= wdata_d;
            send_valid_q <= send_valid_d;
            send_data_q  <= send_data_d;
        end
    end

    // RAM is never cleared; reset only suppresses a write landing on the reset edge.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule
